host_queue_scheduler: RTL and testbench

//  Scheduler between the host input queue and the host output interface. Tracks occupancy of the
//  32-slot TS descriptor RAM (exported as ov_ts_cnt to the input queue's overflow check), picks the next

---
 rtl/host_queue_scheduler.sv | 117 +++++++++++
 tb/tb_host_queue_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_queue_scheduler.sv
// host_queue_scheduler: picks TS (round-robin over occupied RAM slots, strict priority) or NTS FIFO descriptors
// and hands them out on valid/ready; define HQS_NTS_ANTISTARVE_EN to force an NTS grant after TS_BURST_MAX TS grants.
module host_queue_scheduler #(
  parameter int RD_LATENCY   = 2,
  parameter int TS_BURST_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ts_descriptor_wr,
  input  logic [4:0]  iv_ts_descriptor_waddr,
  output logic [31:0] ov_ts_cnt,
  output logic        o_ts_ram_rd,
  output logic [4:0]  ov_ts_ram_raddr,
  input  logic [12:0] iv_ts_ram_rdata,
  input  logic        i_nts_fifo_empty,
  output logic        o_nts_fifo_rd,
  input  logic [12:0] iv_nts_fifo_rdata,
  output logic [12:0] ov_descriptor,
  output logic        o_descriptor_ts,
  output logic        o_descriptor_valid,
  input  logic        i_descriptor_ready,
  output logic        o_ts_conflict_pulse,
  output logic [15:0] ov_ts_sched_cnt,
  output logic [15:0] ov_nts_sched_cnt
);
  typedef enum logic [2:0] {IDLE, TS_RD, NTS_RD, WAIT, OUT} state_t;
  state_t state, state_nxt;
  logic [4:0] ptr, slot, sel, idx;
  logic [1:0] wcnt;
  logic found, nts_turn, grant_ts, grant_nts, latch, src_ts;

  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 1; i <= 32; i++) begin
      idx = ptr + 5'(i);
      if (!found && ov_ts_cnt[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end

`ifdef HQS_NTS_ANTISTARVE_EN
  logic [7:0] burst;
  assign nts_turn = burst >= 8'(TS_BURST_MAX) && !i_nts_fifo_empty;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) burst <= '0;
    else if (!found || grant_nts) burst <= '0;
    else if (grant_ts && burst != 8'hff) burst <= burst + 8'd1;
`else
  assign nts_turn = 1'b0;
`endif

  assign grant_ts = state == IDLE && found && !nts_turn;
  assign grant_nts = state == IDLE && !i_nts_fifo_empty && !grant_ts;
  assign o_ts_ram_rd = state == TS_RD;
  assign o_nts_fifo_rd = state == NTS_RD;
  assign ov_ts_ram_raddr = slot;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    latch = 1'b0;
    unique case (state)
      IDLE: state_nxt = grant_ts ? TS_RD : grant_nts ? NTS_RD : IDLE;
      TS_RD, NTS_RD: begin
        latch = RD_LATENCY == 1;
        state_nxt = latch ? OUT : WAIT;
      end
      WAIT: begin
        latch = wcnt == 2'(RD_LATENCY - 2);
        state_nxt = latch ? OUT : WAIT;
      end
      OUT: state_nxt = i_descriptor_ready ? IDLE : OUT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= 5'd31;
      slot <= '0;
      src_ts <= 1'b0;
      wcnt <= '0;
      ov_ts_cnt <= '0;
      o_ts_conflict_pulse <= 1'b0;
      ov_descriptor <= '0;
      o_descriptor_ts <= 1'b0;
      o_descriptor_valid <= 1'b0;
      ov_ts_sched_cnt <= '0;
      ov_nts_sched_cnt <= '0;
    end else begin
      ov_ts_cnt <= (ov_ts_cnt & ~(o_ts_ram_rd ? 32'd1 << slot : 32'd0))
                 | (i_ts_descriptor_wr ? 32'd1 << iv_ts_descriptor_waddr : 32'd0);
      o_ts_conflict_pulse <= i_ts_descriptor_wr && ov_ts_cnt[iv_ts_descriptor_waddr];
      wcnt <= state == WAIT ? wcnt + 2'd1 : 2'd0;
      if (grant_ts) slot <= sel;
      if (grant_ts || grant_nts) src_ts <= grant_ts;
      if (o_ts_ram_rd) ptr <= slot;
      if (latch) begin
        ov_descriptor <= src_ts ? iv_ts_ram_rdata : iv_nts_fifo_rdata;
        o_descriptor_ts <= src_ts;
        o_descriptor_valid <= 1'b1;
      end
      if (state == OUT && i_descriptor_ready) begin
        o_descriptor_valid <= 1'b0;
        if (o_descriptor_ts) ov_ts_sched_cnt <= ov_ts_sched_cnt + 16'd1;
        else ov_nts_sched_cnt <= ov_nts_sched_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_host_queue_scheduler.sv
// tb_host_queue_scheduler: randomized scoreboard bench; expected delivery order comes from a slot-set/queue model.
module tb_host_queue_scheduler;
  localparam int TS_BURST_MAX = 8;
  logic clk = 1'b0;
  logic rst_n, wr, fifo_empty, fifo_rd, ts_rd, valid, ready, ts_flag, conflict;
  logic [4:0] waddr, raddr;
  logic [12:0] wdata, ts_rdata, nts_rdata, desc;
  logic [31:0] ts_cnt;
  logic [15:0] ts_sched, nts_sched;
  logic [12:0] mem [32];
  logic [12:0] fifo_q[$];
  int fifo_n;
  logic [13:0] expq[$];
  logic [31:0] m_occ;
  logic [12:0] m_dat [32];
  logic [12:0] m_fq[$];
  logic [4:0] m_ptr;
  int m_burst, m_ts_n, m_nts_n, checks, failures;

  always #5 clk = ~clk;
  assign fifo_empty = fifo_n == 0;

  host_queue_scheduler #(.RD_LATENCY(2), .TS_BURST_MAX(TS_BURST_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ts_descriptor_wr(wr), .iv_ts_descriptor_waddr(waddr),
    .ov_ts_cnt(ts_cnt), .o_ts_ram_rd(ts_rd), .ov_ts_ram_raddr(raddr), .iv_ts_ram_rdata(ts_rdata),
    .i_nts_fifo_empty(fifo_empty), .o_nts_fifo_rd(fifo_rd), .iv_nts_fifo_rdata(nts_rdata),
    .ov_descriptor(desc), .o_descriptor_ts(ts_flag), .o_descriptor_valid(valid),
    .i_descriptor_ready(ready), .o_ts_conflict_pulse(conflict),
    .ov_ts_sched_cnt(ts_sched), .ov_nts_sched_cnt(nts_sched)
  );

  // RAM and FIFO with one register stage of read latency after the strobe
  always @(posedge clk) begin
    if (wr) mem[waddr] <= wdata;
    if (ts_rd) begin
      checks++;
      if (!ts_cnt[raddr]) begin
        failures++;
        $display("FAIL ts_rd_free_slot slot=%0d occ=%h required_bit=1", raddr, ts_cnt);
      end
      ts_rdata <= mem[raddr];
    end
    if (fifo_rd) begin
      checks++;
      if (fifo_q.size() == 0) begin
        failures++;
        $display("FAIL nts_rd_when_empty got=read required=no_read");
      end else begin
        nts_rdata <= fifo_q.pop_front();
        fifo_n--;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL desc_unexpected got ts=%0d desc=%h required=none", ts_flag, desc);
      end else begin
        if ({ts_flag, desc} !== expq[0]) begin
          failures++;
          $display("FAIL desc got ts=%0d desc=%h required ts=%0d desc=%h", ts_flag, desc, expq[0][13], expq[0][12:0]);
        end
        if (ready) void'(expq.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] next_slot();
    logic [4:0] s;
    for (int i = 1; i <= 32; i++) begin
      s = m_ptr + 5'(i);
      if (m_occ[s]) return s;
    end
    return m_ptr;
  endfunction

  function automatic void model_schedule();
    logic [4:0] s;
    bit nts_turn;
    while (m_occ != 0 || m_fq.size() != 0) begin
      if (m_occ == 0) m_burst = 0;
      nts_turn = 1'b0;
`ifdef HQS_NTS_ANTISTARVE_EN
      nts_turn = m_burst >= TS_BURST_MAX && m_fq.size() != 0;
`endif
      if (m_occ != 0 && !nts_turn) begin
        s = next_slot();
        m_occ[s] = 1'b0;
        m_ptr = s;
        expq.push_back({1'b1, m_dat[s]});
        m_ts_n++;
        m_burst++;
      end else begin
        expq.push_back({1'b0, m_fq.pop_front()});
        m_nts_n++;
        m_burst = 0;
      end
    end
  endfunction

  function automatic void reset_model();
    m_occ = '0;
    m_ptr = 5'd31;
    m_burst = 0;
    m_ts_n = 0;
    m_nts_n = 0;
    expq.delete();
    m_fq.delete();
    fifo_q.delete();
    fifo_n = 0;
  endfunction

  task automatic push_fifo(input logic [12:0] d);
    fifo_q.push_back(d);
    fifo_n++;
    m_fq.push_back(d);
  endtask

  task automatic ts_write(input logic [4:0] a, input logic [12:0] d, input logic conf);
    wr = 1'b1;
    waddr = a;
    wdata = d;
    m_occ[a] = 1'b1;
    m_dat[a] = d;
    @(posedge clk); #1;
    wr = 1'b0;
    chk("conflict_pulse", 32'(conflict), 32'(conf));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic wait_ts_rd();
    int n = 0;
    while (!ts_rd && n < 100) begin @(posedge clk); #1; n++; end
    chk("ts_rd_timeout", 32'(ts_rd), 32'd1);
  endtask

  task automatic start_block();
    push_fifo({$urandom_range(0, 1) != 0 ? 4'hf : 4'($urandom), 9'($urandom)});
    model_schedule();
    wait_valid();
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 5000) begin
      ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
      n++;
    end
    ready = 1'b0;
    chk("drain_left", 32'(expq.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("occ_after_drain", ts_cnt, 32'd0);
    chk("ts_sched_cnt", 32'(ts_sched), 32'(16'(m_ts_n)));
    chk("nts_sched_cnt", 32'(nts_sched), 32'(16'(m_nts_n)));
  endtask

  task automatic run_batch(input int n_rand, input int n_fifo, input logic [31:0] force_mask);
    logic [4:0] a;
    ready = 1'b0;
    start_block();
    for (int i = 31; i >= 0; i--)
      if (force_mask[i]) ts_write(5'(i), 13'($urandom), m_occ[i]);
    for (int i = 0; i < n_rand; i++) begin
      a = 5'($urandom_range(0, 31));
      ts_write(a, 13'($urandom), m_occ[a]);
    end
    for (int i = 0; i < n_fifo; i++) push_fifo(13'($urandom));
    repeat (10) @(posedge clk);
    #1;
    chk("held_valid", 32'(valid), 32'd1);
    chk("occupancy", ts_cnt, m_occ);
    chk("nts_cnt_before_ready", 32'(nts_sched), 32'(16'(m_nts_n - 1)));
    model_schedule();
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    wr = 1'b0;
    waddr = '0;
    wdata = '0;
    ready = 1'b0;
    ts_rdata = '0;
    nts_rdata = '0;
    checks = 0;
    failures = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_occ", ts_cnt, 32'd0);
    chk("rst_ts_rd", 32'(ts_rd), 32'd0);
    chk("rst_nts_rd", 32'(fifo_rd), 32'd0);
    chk("rst_desc", 32'(desc), 32'd0);
    chk("rst_ts_sched", 32'(ts_sched), 32'd0);
    chk("rst_nts_sched", 32'(nts_sched), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    rst_n = 1'b1;
    run_batch(0, 0, 32'h0000_0088);
    run_batch(0, 1, 32'h4000_0020);
    for (int b = 0; b < 6; b++) run_batch($urandom_range(1, 12), $urandom_range(0, 6), '0);
    run_batch(0, 5, 32'hffff_ffff);
    run_batch(4, 3, 32'hffff_ffff);
    // slot 9 rewritten in the very cycle it is being read: set must win
    ready = 1'b0;
    start_block();
    ts_write(5'd9, 13'h0a5a, m_occ[9]);
    model_schedule();
    ready = 1'b1;
    wait_ts_rd();
    chk("slot9_raddr", 32'(raddr), 32'd9);
    ts_write(5'd9, 13'h1234, 1'b1);
    chk("slot9_kept", 32'(ts_cnt[9]), 32'd1);
    model_schedule();
    drain();
    // async reset while a TS read is outstanding
    ts_write(5'd12, 13'h0777, m_occ[12]);
    wait_ts_rd();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_ts_rd", 32'(ts_rd), 32'd0);
    chk("midrst_nts_rd", 32'(fifo_rd), 32'd0);
    chk("midrst_occ", ts_cnt, 32'd0);
    chk("midrst_desc", 32'(desc), 32'd0);
    chk("midrst_ts_sched", 32'(ts_sched), 32'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_batch(0, 1, 32'h0010_0001);
    for (int b = 0; b < 4; b++) run_batch($urandom_range(1, 20), $urandom_range(0, 10), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
